// File: rtl/marquee_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : marquee_scheduler                                          |
// | Description : Four-cell marquee sequencer (fade-in, looped scroll,       |
// |               fade-out). Define MARQUEE_FADE_EN to build the fade stages.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module marquee_scheduler #(
    parameter int         MAX_LEN = 32,
    parameter logic [4:0] BLANK   = 5'd26
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       step_tick,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [5:0] msg_len,
    input  logic [1:0] loops,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] c1,
    output logic [7:0] c2,
    output logic [7:0] c3,
    output logic [7:0] c4,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SCROLL = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd4;
`ifdef MARQUEE_FADE_EN
    localparam logic [2:0] c_FADE_IN      = 3'd1;
    localparam logic [2:0] c_FADE_OUT     = 3'd3;
    localparam logic [2:0] c_LAUNCH_STATE = c_FADE_IN;
    localparam logic [2:0] c_LAUNCH_BRIGHT = 3'd0;
    localparam logic [2:0] c_END_STATE    = c_FADE_OUT;
`else
    localparam logic [2:0] c_LAUNCH_STATE = c_SCROLL;
    localparam logic [2:0] c_LAUNCH_BRIGHT = 3'd7;
    localparam logic [2:0] c_END_STATE    = c_DONE;
`endif

    logic [4:0] r_buf [MAX_LEN];
    logic [2:0] r_state, w_state_nxt;
    logic [5:0] r_len, w_len_nxt;
    logic [1:0] r_loops_left, w_loops_nxt;
    logic [4:0] r_pos, w_pos_nxt;
    logic [2:0] r_bright, w_bright_nxt;

    logic       w_start_ok;
    logic [5:0] w_len_clamp;
    logic [5:0] w_pos_plus;
    logic [4:0] w_pos_wrap;
    logic       w_blank;
    logic [3:0][7:0] w_cell_nxt;

    assign w_start_ok  = start && !stop && (msg_len != 6'd0);
    assign w_len_clamp = (msg_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : msg_len;
    assign w_pos_plus  = {1'b0, r_pos} + 6'd1;
    assign w_pos_wrap  = (w_pos_plus >= r_len) ? 5'd0 : w_pos_plus[4:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_loops_nxt  = r_loops_left;
        w_pos_nxt    = r_pos;
        w_bright_nxt = r_bright;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt  = c_LAUNCH_STATE;
                    w_len_nxt    = w_len_clamp;
                    w_loops_nxt  = loops;
                    w_pos_nxt    = 5'd0;
                    w_bright_nxt = c_LAUNCH_BRIGHT;
                end
            end
`ifdef MARQUEE_FADE_EN
            c_FADE_IN: begin
                // Nothing lit yet: an abort has nothing to fade out.
                if (stop) begin
                    w_state_nxt = (r_bright == 3'd0) ? c_DONE : c_FADE_OUT;
                end else if (step_tick) begin
                    w_bright_nxt = r_bright + 3'd1;
                    if (r_bright == 3'd6) w_state_nxt = c_SCROLL;
                end
            end
            c_FADE_OUT: begin
                if (step_tick) begin
                    w_bright_nxt = r_bright - 3'd1;
                    if (r_bright == 3'd1) w_state_nxt = c_DONE;
                end
            end
`endif
            c_SCROLL: begin
                if (stop) begin
                    w_state_nxt = c_END_STATE;
                end else if (step_tick) begin
                    w_pos_nxt = w_pos_wrap;
                    if (w_pos_wrap == 5'd0) begin
                        if (r_loops_left == 2'd0) w_state_nxt = c_END_STATE;
                        else                      w_loops_nxt = r_loops_left - 2'd1;
                    end
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign w_blank = (w_state_nxt == c_IDLE) || (w_state_nxt == c_DONE);

    // pos+k can exceed len several times over when len < 4.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_cell
            logic [5:0] w_idx;
            always_comb begin
                w_idx = {1'b0, w_pos_nxt} + 6'(k);
                for (int i = 0; i < 3; i++) begin
                    if (w_idx >= w_len_nxt) w_idx = w_idx - w_len_nxt;
                end
            end
            assign w_cell_nxt[k] = w_blank ? {3'd0, BLANK}
                                           : {w_bright_nxt, r_buf[w_idx[4:0]]};
        end
    endgenerate

    always_ff @(posedge clk_50mhz) begin
        if (wr_en && (r_state == c_IDLE)) r_buf[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_len        <= 6'd0;
            r_loops_left <= 2'd0;
            r_pos        <= 5'd0;
            r_bright     <= 3'd0;
            c1           <= {3'd0, BLANK};
            c2           <= {3'd0, BLANK};
            c3           <= {3'd0, BLANK};
            c4           <= {3'd0, BLANK};
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_loops_left <= w_loops_nxt;
            r_pos        <= w_pos_nxt;
            r_bright     <= w_bright_nxt;
            c1           <= w_cell_nxt[0];
            c2           <= w_cell_nxt[1];
            c3           <= w_cell_nxt[2];
            c4           <= w_cell_nxt[3];
        end
    end

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_DONE);

endmodule
`default_nettype wire
